// File: rtl/noise_beat_player.sv
// Beat sequencer and enveloped LFSR noise voice for the drum/noise track.
// Beat index feeds an external pattern decider whose is_noise gates the envelope.
module noise_beat_player #(
    parameter int unsigned BEAT_DIV   = 12_500_000,
    parameter int unsigned BEAT_LEN   = 64,
    parameter int unsigned SAMPLE_DIV = 2272,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned AMP_SHIFT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        restart,
    input  logic        is_noise,
    output logic [11:0] ibeatNum,
    output logic        beat_tick,
    output logic [15:0] sample,
    output logic        active
);

    localparam int unsigned BDW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int unsigned SDW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [BDW-1:0] BEAT_LAST   = BDW'(BEAT_DIV - 1);
    localparam logic [SDW-1:0] SAMPLE_LAST = SDW'(SAMPLE_DIV - 1);
    localparam logic [11:0]    BEAT_MAX    = 12'(BEAT_LEN - 1);
    localparam logic [15:0]    LFSR_MASK   = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    function automatic logic [3:0] gain_up(input logic [3:0] g);
        return (g == 4'd15) ? 4'd15 : g + 4'd1;
    endfunction

    function automatic logic [3:0] gain_down(input logic [3:0] g);
        return (g == 4'd0) ? 4'd0 : g - 4'd1;
    endfunction

    logic [BDW-1:0] beat_cnt_r;
    logic [11:0]    beat_r;
    logic           beat_tick_r;
    logic           beat_wrap_s;

    logic [SDW-1:0] sample_cnt_r;
    logic           stick_s;

    logic [15:0]    lfsr_r;
    logic [15:0]    lfsr_shift_s;
    logic [15:0]    lfsr_next_s;

    env_state_t     state_r;
    env_state_t     state_next_s;
    logic [3:0]     gain_r;
    logic [3:0]     gain_next_s;
    logic           go_s;

    logic signed [15:0] nv_s;
    logic signed [20:0] nv_ext_s;
    logic signed [20:0] gain_ext_s;
    logic signed [20:0] prod_s;
    logic [15:0]        sample_next_s;
    logic               active_next_s;
    logic [15:0]        sample_r;
    logic               active_r;

    assign beat_wrap_s = en && (beat_cnt_r == BEAT_LAST);
    assign stick_s     = (sample_cnt_r == SAMPLE_LAST);
    assign go_s        = is_noise && en;

    assign ibeatNum  = beat_r;
    assign beat_tick = beat_tick_r;
    assign sample    = sample_r;
    assign active    = active_r;

    // Beat divider, beat index and beat pulse; restart overrides a coincident wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r  <= '0;
            beat_r      <= 12'd0;
            beat_tick_r <= 1'b0;
        end else if (restart) begin
            beat_cnt_r  <= '0;
            beat_r      <= 12'd0;
            beat_tick_r <= 1'b0;
        end else if (beat_wrap_s) begin
            beat_cnt_r  <= '0;
            beat_r      <= (beat_r == BEAT_MAX) ? 12'd0 : beat_r + 12'd1;
            beat_tick_r <= 1'b1;
        end else if (en) begin
            beat_cnt_r  <= beat_cnt_r + BDW'(1);
            beat_tick_r <= 1'b0;
        end else begin
            beat_tick_r <= 1'b0;
        end
    end

    // Free-running sample-rate divider, independent of en so releases finish while paused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_r <= '0;
        end else if (stick_s) begin
            sample_cnt_r <= '0;
        end else begin
            sample_cnt_r <= sample_cnt_r + SDW'(1);
        end
    end

    // Galois LFSR next value with a guard against the all-zero lock-up state
    always_comb begin
        lfsr_shift_s = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_MASK : 16'h0000);
        if (lfsr_shift_s == 16'h0000) begin
            lfsr_next_s = LFSR_SEED;
        end else begin
            lfsr_next_s = lfsr_shift_s;
        end
    end

    // LFSR register, advanced once per sample tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (stick_s) begin
            lfsr_r <= lfsr_next_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Envelope state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gain_r  <= 4'd0;
        end else begin
            state_r <= state_next_s;
            gain_r  <= gain_next_s;
        end
    end

    // Envelope next state and gain; ramps resume from the current gain in either direction
    always_comb begin
        state_next_s = state_r;
        gain_next_s  = gain_r;
        if (stick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_next_s = ST_ATTACK;
                        gain_next_s  = 4'd1;
                    end else begin
                        state_next_s = ST_IDLE;
                        gain_next_s  = 4'd0;
                    end
                end
                ST_ATTACK, ST_RELEASE: begin
                    if (go_s) begin
                        gain_next_s  = gain_up(gain_r);
                        state_next_s = (gain_up(gain_r) == 4'd15) ? ST_SUSTAIN : ST_ATTACK;
                    end else begin
                        gain_next_s  = gain_down(gain_r);
                        state_next_s = (gain_down(gain_r) == 4'd0) ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_SUSTAIN: begin
                    if (go_s) begin
                        state_next_s = ST_SUSTAIN;
                        gain_next_s  = 4'd15;
                    end else begin
                        state_next_s = ST_RELEASE;
                        gain_next_s  = 4'd14;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    gain_next_s  = 4'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
            gain_next_s  = gain_r;
        end
    end

    // Output decode: scaled noise times the gain taking effect on this tick
    always_comb begin
        nv_s       = $signed(lfsr_r) >>> AMP_SHIFT;
        nv_ext_s   = {{5{nv_s[15]}}, nv_s};
        gain_ext_s = {17'd0, gain_next_s};
        prod_s     = nv_ext_s * gain_ext_s;
        active_next_s = (state_next_s != ST_IDLE);
        if (stick_s) begin
            sample_next_s = prod_s[19:4];
        end else begin
            sample_next_s = sample_r;
        end
    end

    // Registered audio sample and activity flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r <= 16'h0000;
            active_r <= 1'b0;
        end else begin
            sample_r <= sample_next_s;
            active_r <= active_next_s;
        end
    end

endmodule

// File: tb/tb_noise_beat_player.sv
// Self-checking bench for noise_beat_player: directed beat-timing table plus
// randomized en/restart traffic compared against a behavioural model.
module tb_noise_beat_player;

    localparam int          BDIV  = 4;
    localparam int          BLEN  = 64;
    localparam int          SDIV  = 2;
    localparam int          SHIFT = 3;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        restart;
    logic        is_noise;
    logic [11:0] ibeatNum;
    logic        beat_tick;
    logic [15:0] sample;
    logic        active;

    bit pat_mode;
    int n_checks;
    int n_errors;

    // behavioural model state
    int          m_bcnt, m_beat, m_sdiv, m_gain;
    bit          m_tick, m_active;
    logic [15:0] m_lfsr, m_sample;

    typedef struct {
        bit en;
        bit rs;
        bit tick;
        int beat;
    } vec_t;
    vec_t tbl[19];

    noise_beat_player #(
        .BEAT_DIV  (BDIV),
        .BEAT_LEN  (BLEN),
        .SAMPLE_DIV(SDIV),
        .LFSR_SEED (SEED),
        .AMP_SHIFT (SHIFT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .restart  (restart),
        .is_noise (is_noise),
        .ibeatNum (ibeatNum),
        .beat_tick(beat_tick),
        .sample   (sample),
        .active   (active)
    );

    // pattern decider: noise on beats 0-15 and 32-47
    assign is_noise = pat_mode && ((ibeatNum < 12'd16) || (ibeatNum >= 12'd32 && ibeatNum < 12'd48));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit noise_at(input int b, input bit pm);
        return pm && ((b < 16) || (b >= 32 && b < 48));
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        if (n == 16'h0000) n = SEED;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bcnt = 0; m_beat = 0; m_tick = 1'b0; m_sdiv = 0;
        m_gain = 0; m_active = 1'b0; m_sample = 16'h0000; m_lfsr = SEED;
    endtask

    task automatic model_step(input bit e, input bit r);
        bit go, stk;
        int nv, prod;
        go  = noise_at(m_beat, pat_mode) && e;
        stk = (m_sdiv == SDIV - 1);
        if (r) begin
            m_bcnt = 0; m_beat = 0; m_tick = 1'b0;
        end else if (e) begin
            if (m_bcnt == BDIV - 1) begin
                m_bcnt = 0; m_tick = 1'b1; m_beat = (m_beat + 1) % BLEN;
            end else begin
                m_bcnt++; m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        m_sdiv = stk ? 0 : m_sdiv + 1;
        if (stk) begin
            if (go) m_gain = (m_gain < 15) ? m_gain + 1 : 15;
            else    m_gain = (m_gain > 0) ? m_gain - 1 : 0;
            nv       = int'($signed(m_lfsr)) >>> SHIFT;
            prod     = (nv * m_gain) >>> 4;
            m_sample = 16'(prod);
            m_active = (m_gain != 0);
            m_lfsr   = lfsr_adv(m_lfsr);
        end
    endtask

    task automatic cycle(input bit e, input bit r);
        en      = e;
        restart = r;
        model_step(e, r);
        @(negedge clk);
    endtask

    task automatic cmp_model();
        chk("ibeatNum", ibeatNum, m_beat);
        chk("beat_tick", beat_tick, m_tick);
        chk("sample", sample, m_sample);
        chk("active", active, m_active);
    endtask

    initial begin
        int ticks, saved;
        bit tick_seen, e, r;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; en = 1'b0; restart = 1'b0; pat_mode = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 2};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("rst_beat", ibeatNum, 0);
        chk("rst_tick", beat_tick, 0);
        chk("rst_sample", sample, 0);
        chk("rst_active", active, 0);
        rst_n = 1'b1;
        model_reset();

        // beat timing, pause and restart-over-wrap with the decider silent
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].en, tbl[i].rs);
            chk("tbl_tick", beat_tick, tbl[i].tick);
            chk("tbl_beat", ibeatNum, tbl[i].beat);
            chk("tbl_sample", sample, 0);
            chk("tbl_active", active, 0);
        end

        // full pattern: attack, sustain, release, re-attack, wrap at 64
        pat_mode = 1'b1;
        ticks = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b0);
            cmp_model();
            if (beat_tick) begin
                ticks++;
                if (ticks == 64) chk("wrap_64", ibeatNum, 0);
            end
        end
        chk("tick_count", ticks, 75);
        chk("sustain_active", active, 1);

        // pause in sustain: beat frozen, envelope releases on free-running ticks
        saved = ibeatNum;
        tick_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0);
            cmp_model();
            tick_seen |= beat_tick;
        end
        chk("pause_beat", ibeatNum, saved);
        chk("pause_tick", tick_seen, 0);
        chk("pause_active", active, 0);
        chk("pause_sample", sample, 0);

        // randomized en/restart traffic
        for (int i = 0; i < 2000; i++) begin
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 63) == 0);
            cycle(e, r);
            cmp_model();
        end

        // async reset while sustaining
        cycle(1'b1, 1'b1);
        cmp_model();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0);
            cmp_model();
        end
        chk("pre_rst_active", active, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sample", sample, 0);
        chk("arst_beat", ibeatNum, 0);
        chk("arst_active", active, 0);
        chk("arst_tick", beat_tick, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0);
            cmp_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
